// File: rtl/button_conditioner.sv
// Button front end: two-flop synchroniser, per-channel debounce, press/release/long-press
// pulses and a latched one-hot selection register. Every output comes straight from a flop.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] selected
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  logic [N_BTN-1:0] meta_q, sync_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] sel_q, sel_d;
  logic [DW-1:0]    dcnt_q [N_BTN];
  logic [DW-1:0]    dcnt_d [N_BTN];
  logic [HW-1:0]    hcnt_q [N_BTN];
  logic [HW-1:0]    hcnt_d [N_BTN];

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i] = '0;
      hcnt_d[i] = hcnt_q[i];
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync_q[i] != level_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i]   = sync_q[i];
          press_d[i]   = sync_q[i];
          release_d[i] = ~sync_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
      // Hold counter saturates at LONG_CYCLES so the long pulse fires only once per hold.
      if (!level_d[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] != HW'(LONG_CYCLES)) begin
        hcnt_d[i] = hcnt_q[i] + HW'(1);
        long_d[i] = (hcnt_q[i] == HW'(LONG_CYCLES - 1));
      end
    end

    // Lowest-index press wins; a long press with no concurrent press deselects.
    sel_d = sel_q;
    if (|press_q) begin
      sel_d = press_q & (~press_q + N_BTN'(1));
    end else if (|long_q) begin
      sel_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      sel_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      sel_q     <= sel_d;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign selected    = sel_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed button scenarios; expected pulses and selection
// changes (tagged with their cycle number) are queued and checked by a separate monitor.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int EW   = 32 + 4 * N;
  localparam int SW   = 32 + N;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, selected;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c;
  logic         mon_en   = 1'b0;
  logic [N-1:0] prev_sel = '0;

  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] sel_q[$];

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .selected(selected)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] l, input logic [N-1:0] lv);
    logic [31:0] at32;
    at32 = at;
    exp_q.push_back({at32, p, r, l, lv});
  endtask

  task automatic push_sel(input int at, input logic [N-1:0] s);
    logic [31:0] at32;
    at32 = at;
    sel_q.push_back({at32, s});
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({btn_level, btn_press, btn_release, btn_long, selected} !== '0) begin
      bad++;
      $display("FAIL %s cyc=%0d: lvl=%b prs=%b rel=%b lng=%b sel=%b required all 0",
               name, cyc, btn_level, btn_press, btn_release, btn_long, selected);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got, want;
    logic [SW-1:0] sgot, swant;
    if (mon_en) begin
      if ((btn_press | btn_release | btn_long) != '0) begin
        got = {cyc[31:0], btn_press, btn_release, btn_long, btn_level};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL event: unexpected cyc=%0d prs=%b rel=%b lng=%b lvl=%b",
                   cyc, btn_press, btn_release, btn_long, btn_level);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL event: got cyc=%0d prs=%b rel=%b lng=%b lvl=%b required cyc=%0d prs=%b rel=%b lng=%b lvl=%b",
                     got[EW-1:4*N], got[4*N-1:3*N], got[3*N-1:2*N], got[2*N-1:N], got[N-1:0],
                     want[EW-1:4*N], want[4*N-1:3*N], want[3*N-1:2*N], want[2*N-1:N], want[N-1:0]);
          end
        end
      end
      if (selected !== prev_sel) begin
        sgot = {cyc[31:0], selected};
        total++;
        if (sel_q.size() == 0) begin
          bad++;
          $display("FAIL selected: unexpected change cyc=%0d sel=%b", cyc, selected);
        end else begin
          swant = sel_q.pop_front();
          if (sgot !== swant) begin
            bad++;
            $display("FAIL selected: got cyc=%0d sel=%b required cyc=%0d sel=%b",
                     sgot[SW-1:N], sgot[N-1:0], swant[SW-1:N], swant[N-1:0]);
          end
        end
        prev_sel = selected;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    btn_raw = '0;

    // Reset then idle.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_zero("idle_after_reset");
    end
    mon_en = 1'b1;

    // Clean press and release on hoods.
    c = cyc;
    btn_raw = 5'b00010;
    push_ev(c + 6, 5'b00010, 5'b00000, 5'b00000, 5'b00010);
    push_sel(c + 7, 5'b00010);
    step(10);
    c = cyc;
    btn_raw = 5'b00000;
    push_ev(c + 6, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
    step(10);

    // Bounce rejection on seat: 1, 2, 3 cycle pulses, then a stable hold.
    btn_raw[4] = 1'b1; step(1);
    btn_raw[4] = 1'b0; step(1);
    btn_raw[4] = 1'b1; step(2);
    btn_raw[4] = 1'b0; step(1);
    btn_raw[4] = 1'b1; step(3);
    btn_raw[4] = 1'b0; step(1);
    c = cyc;
    btn_raw[4] = 1'b1;
    push_ev(c + 6, 5'b10000, 5'b00000, 5'b00000, 5'b10000);
    push_sel(c + 7, 5'b10000);
    step(8);
    c = cyc;
    btn_raw[4] = 1'b0;
    push_ev(c + 6, 5'b00000, 5'b10000, 5'b00000, 5'b00000);
    step(10);

    // Simultaneous presses on tops and seat: lowest index is selected.
    c = cyc;
    btn_raw = 5'b10100;
    push_ev(c + 6, 5'b10100, 5'b00000, 5'b00000, 5'b10100);
    push_sel(c + 7, 5'b00100);
    step(8);
    c = cyc;
    btn_raw = 5'b00000;
    push_ev(c + 6, 5'b00000, 5'b10100, 5'b00000, 5'b00000);
    step(10);

    // Long press on drops: select, then deselect on the long pulse.
    c = cyc;
    btn_raw = 5'b00001;
    push_ev(c + 6, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
    push_sel(c + 7, 5'b00001);
    push_ev(c + 6 + LONG - 1, 5'b00000, 5'b00000, 5'b00001, 5'b00001);
    push_sel(c + 7 + LONG - 1, 5'b00000);
    step(30);
    c = cyc;
    btn_raw = 5'b00000;
    push_ev(c + 6, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    step(10);

    // Reset while bar is held: state discarded, then re-debounced from level 0.
    c = cyc;
    btn_raw = 5'b01000;
    push_ev(c + 6, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
    push_sel(c + 7, 5'b01000);
    step(10);
    c = cyc;
    rst = 1'b1;
    push_sel(c + 1, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_zero("reset_while_held");
    end
    c = cyc;
    rst = 1'b0;
    push_ev(c + 6, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
    push_sel(c + 7, 5'b01000);
    step(9);
    c = cyc;
    btn_raw = 5'b00000;
    push_ev(c + 6, 5'b00000, 5'b01000, 5'b00000, 5'b00000);
    step(12);

    // Every queued expectation must have been consumed.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL event_drain: got %0d pending required 0", exp_q.size());
    end
    total++;
    if (sel_q.size() != 0) begin
      bad++;
      $display("FAIL selected_drain: got %0d pending required 0", sel_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
